// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator: scans A and B from the MSB down,
// one bit per clock, and reports eq/lt/gt plus the number of compare cycles used.
module serial_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic                       eq,
  output logic                       lt,
  output logic                       gt,
  output logic [$clog2(WIDTH+1)-1:0] cycles
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             hit_q, lt_q, gt_q;

  logic bit_a, bit_b, differ, last;
  logic hit_nxt, lt_nxt, gt_nxt;

  assign bit_a  = a_q[idx];
  assign bit_b  = b_q[idx];
  assign differ = bit_a ^ bit_b;
  assign last   = (idx == '0);

  // Only the most significant difference decides the ordering.
  assign hit_nxt = hit_q | differ;
  assign lt_nxt  = hit_q ? lt_q : (~bit_a & bit_b);
  assign gt_nxt  = hit_q ? gt_q : (bit_a & ~bit_b);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last || (EARLY_EXIT && differ)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      gt     <= 1'b0;
      cycles <= '0;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      hit_q  <= 1'b0;
      lt_q   <= 1'b0;
      gt_q   <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: if (start) begin
          a_q    <= a;
          b_q    <= b;
          idx    <= IW'(WIDTH-1);
          eq     <= 1'b0;
          lt     <= 1'b0;
          gt     <= 1'b0;
          cycles <= '0;
          hit_q  <= 1'b0;
          lt_q   <= 1'b0;
          gt_q   <= 1'b0;
        end
        RUN: begin
          cycles <= cycles + 1'b1;
          hit_q  <= hit_nxt;
          lt_q   <= lt_nxt;
          gt_q   <= gt_nxt;
          // Flags stay 0 while scanning and are published together on exit.
          if (state_nxt == DONE) begin
            eq <= ~hit_nxt;
            lt <= lt_nxt;
            gt <= gt_nxt;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl: an early-exit and a full-scan instance,
// results checked against a behavioural model through per-instance scoreboards.
module tb_serial_compare_ctrl;

  logic       clk, rst_n;
  logic       start, start0;
  logic [7:0] a, b, a0, b0;
  logic       busy, done, eq, lt, gt;
  logic       busy0, done0, eq0, lt0, gt0;
  logic [3:0] cycles, cycles0;

  serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt), .cycles(cycles));

  serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .eq(eq0), .lt(lt0), .gt(gt0), .cycles(cycles0));

  typedef struct {
    logic eq, lt, gt;
    int   ncyc;
    int   at;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // c = value of cyc at the negedge before the accepting edge
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input bit ee, input int c);
    exp_t e;
    int   k;
    bit   found;
    k = 8;
    found = 0;
    if (ee)
      for (int i = 7; i >= 0; i--)
        if (!found && x[i] != y[i]) begin
          k = 8 - i;
          found = 1;
        end
    e.eq   = (x == y);
    e.lt   = (x < y);
    e.gt   = (x > y);
    e.ncyc = k;
    e.at   = c + k + 1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) check("unexpected_done", 32'(done), 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("eq", 32'(eq), 32'(e.eq));
        check("lt", 32'(lt), 32'(e.lt));
        check("gt", 32'(gt), 32'(e.gt));
        check("cycles", 32'(cycles), 32'(e.ncyc));
        check("done_time", 32'(cyc), 32'(e.at));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (q0.size() == 0) check("unexpected_done0", 32'(done0), 0);
      else begin
        exp_t e;
        e = q0.pop_front();
        check("eq0", 32'(eq0), 32'(e.eq));
        check("lt0", 32'(lt0), 32'(e.lt));
        check("gt0", 32'(gt0), 32'(e.gt));
        check("cycles0", 32'(cycles0), 32'(e.ncyc));
        check("done_time0", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic wait_done(input bit which);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? done0 : done) && n < 60);
    check(which ? "done0_seen" : "done_seen", 32'(which ? done0 : done), 1);
  endtask

  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    a = x; b = y; start = 1'b1;
    q.push_back(model(x, y, 1'b1, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue0(input logic [7:0] x, input logic [7:0] y);
    a0 = x; b0 = y; start0 = 1'b1;
    q0.push_back(model(x, y, 1'b0, cyc));
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_flags"}, 32'({eq, lt, gt}), 0);
    check({tag, "_cycles"}, 32'(cycles), 0);
  endtask

  logic [7:0] bb_a [3] = '{8'hA5, 8'h80, 8'h12};
  logic [7:0] bb_b [3] = '{8'hA5, 8'h7F, 8'h13};

  initial begin
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0;
    a = '0; b = '0; a0 = '0; b0 = '0;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // equal operands, stray start during RUN must be ignored
    issue(8'hA5, 8'hA5);
    check("run_busy", 32'(busy), 1);
    check("run_flags", 32'({eq, lt, gt}), 0);
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", 32'(busy), 1);
    wait_done(0);
    @(negedge clk);

    issue(8'h80, 8'h7F);
    wait_done(0);
    @(negedge clk);
    issue(8'h12, 8'h13);
    wait_done(0);
    repeat (3) @(negedge clk);
    check("hold_flags", 32'({eq, lt, gt}), 32'(3'b010));
    check("hold_cycles", 32'(cycles), 8);
    check("idle_busy", 32'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      issue(8'($urandom), 8'($urandom));
      wait_done(0);
      @(negedge clk);
    end
    issue(8'hFF, 8'h00);
    wait_done(0);
    @(negedge clk);
    issue(8'h00, 8'h01);
    wait_done(0);
    @(negedge clk);

    // asynchronous reset during the third RUN cycle
    issue(8'h33, 8'h33);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("abort");
    q.delete();
    repeat (2) @(negedge clk);
    check("abort_no_done", 32'(done), 0);
    rst_n = 1'b1;
    issue(8'h01, 8'h00);
    wait_done(0);
    @(negedge clk);

    // start held high across three operations
    a = bb_a[0]; b = bb_b[0]; start = 1'b1;
    q.push_back(model(bb_a[0], bb_b[0], 1'b1, cyc));
    for (int i = 0; i < 3; i++) begin
      wait_done(0);
      if (i < 2) begin
        a = bb_a[i+1]; b = bb_b[i+1];
        q.push_back(model(bb_a[i+1], bb_b[i+1], 1'b1, cyc + 1));
        @(negedge clk);
        check("b2b_idle_busy", 32'(busy), 0);
        check("b2b_idle_done", 32'(done), 0);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    // full-scan instance: MSB difference must not be overwritten
    issue0(8'h80, 8'h7F);
    check("run0_flags", 32'({eq0, lt0, gt0}), 0);
    wait_done(1);
    @(negedge clk);
    issue0(8'h12, 8'h13);
    wait_done(1);
    @(negedge clk);
    issue0(8'h5A, 8'h5A);
    wait_done(1);
    repeat (2) @(negedge clk);

    check("q_empty", 32'(q.size()), 0);
    check("q0_empty", 32'(q0.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_compare_ctrl.md
SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values 2..32.
REQ-002 SHALL have parameter EARLY_EXIT, default 1; 1 = stop at first differing bit, 0 = always scan all WIDTH bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request to compare a and b; sampled only in IDLE.
REQ-006 SHALL have port a  input  WIDTH  operand A, unsigned; sampled with accepted start.
REQ-007 SHALL have port b  input  WIDTH  operand B, unsigned; sampled with accepted start.
REQ-008 SHALL have port busy  output  1  high while state is RUN or DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port eq  output  1  A == B.
REQ-011 SHALL have port lt  output  1  A < B.
REQ-012 SHALL have port gt  output  1  A > B.
REQ-013 SHALL have port cycles  output  $clog2(WIDTH+1)  number of bit-compare cycles used by the last operation.

Function
REQ-014 SHALL implement FSM with states IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE: start=1 at an edge SHALL capture a, b into internal registers, set bit index to WIDTH-1, clear eq/lt/gt/cycles, enter RUN.
REQ-016 start SHALL be ignored in RUN and DONE; operands captured at acceptance SHALL NOT change until the next accepted start.
REQ-017 RUN: each edge SHALL compare captured A[idx] vs B[idx] (1-bit Eq/Lt/Gt function) and increment cycles by 1.
REQ-018 RUN, bits differ, EARLY_EXIT=1: SHALL set gt=1 if A[idx]=1 else lt=1, eq=0, enter DONE.
REQ-019 RUN, bits differ, EARLY_EXIT=0: SHALL latch lt/gt from the first (most significant) difference only; later differences SHALL NOT alter it.
REQ-020 RUN, idx==0 with no difference latched SHALL set eq=1; RUN at idx==0 SHALL always enter DONE.
REQ-021 RUN, otherwise: SHALL decrement idx and remain in RUN.
REQ-022 DONE: done SHALL be 1 for exactly one cycle; next edge SHALL enter IDLE unconditionally.
REQ-023 Latency: with start accepted at edge E0 and k compare edges, done SHALL be high in the cycle following edge Ek; k = WIDTH - (position of MSB difference) when EARLY_EXIT=1 and differs, else k = WIDTH.
REQ-024 eq, lt, gt SHALL be mutually exclusive; exactly one SHALL be high from done until the next accepted start; all SHALL be 0 during RUN.
REQ-025 eq/lt/gt/cycles SHALL hold their values in IDLE after done until a new start is accepted.
REQ-026 Back-to-back: start held high continuously SHALL be accepted on the first IDLE edge after DONE, giving one idle cycle between operations.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, and busy, done, eq, lt, gt, cycles, idx and operand registers to 0.
REQ-028 rst_n asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; first edge with rst_n=1 and start=1 SHALL start a fresh operation.

Verification
REQ-029 WIDTH=8, EARLY_EXIT=1, a=8'hA5, b=8'hA5, start pulse -> busy high, done 8 edges after start edge, eq=1, lt=gt=0, cycles=8.
REQ-030 a=8'h80, b=8'h7F -> done after 1 compare edge, gt=1, cycles=1; a=8'h12, b=8'h13 -> lt=1, cycles=8.
REQ-031 start pulse with a=8'h00, b=8'hFF issued during RUN of A5/A5 -> ignored; result eq=1, cycles=8, busy unchanged.
REQ-032 rst_n low at 3rd RUN cycle -> all outputs 0 at once, no done; after release, a=8'h01, b=8'h00 -> gt=1, cycles=8.
REQ-033 EARLY_EXIT=0, a=8'h80, b=8'h7F -> gt=1 (not overwritten by lower bits), cycles=8, done 8 edges after start.
REQ-034 start held high for 3 operations -> three done pulses, each separated by one idle cycle, results correct per operand set.
